// File: rtl/cell_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cell_mem_arbiter                                           |
// | Description : Owns the single-port 1-bit cell-state RAM and shares it    |
// |               between VGA scan-out (absolute priority while visible),    |
// |               the life-update engine and the manual-setting UI (the two  |
// |               latter served round-robin).                                |
// | Optional    : CELL_TOGGLE_EN - UI toggle requests run as a locked        |
// |               read-modify-write (ARB -> RMW_RD -> RMW_WR).               |
// | Ports       : clk, rst_n (async, active-low)                             |
// |               vga_active/vga_addr -> vga_live                            |
// |               eng_req/we/addr/wdata -> eng_gnt, eng_rdata, eng_rvalid    |
// |               ui_req/toggle/addr/wdata -> ui_gnt, ui_done                |
// |               mem_en/we/addr/wdata -> RAM, mem_rdata <- RAM (1-cycle)    |
// | Read timing : data issued in cycle N leaves the RAM in N+1 and is        |
// |               captured into vga_live / eng_rdata, visible in N+2.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module cell_mem_arbiter #(
  parameter int ADDR_W    = 12,
  parameter int P_PARAM_N = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vga_active,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_live,
  input  logic              eng_req,
  input  logic              eng_we,
  input  logic [ADDR_W-1:0] eng_addr,
  input  logic              eng_wdata,
  output logic              eng_gnt,
  output logic              eng_rdata,
  output logic              eng_rvalid,
  input  logic              ui_req,
  input  logic              ui_toggle,
  input  logic [ADDR_W-1:0] ui_addr,
  input  logic              ui_wdata,
  output logic              ui_gnt,
  output logic              ui_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wdata,
  input  logic              mem_rdata
);

  // Row length is documentation only; no address arithmetic happens here.
  localparam int c_unused_row_cells = P_PARAM_N;

  localparam logic [1:0] c_st_arb   = 2'd0;
  localparam logic [1:0] c_tag_none = 2'd0;
  localparam logic [1:0] c_tag_vga  = 2'd1;
  localparam logic [1:0] c_tag_eng  = 2'd2;
  localparam logic       c_ptr_eng  = 1'b0;
  localparam logic       c_ptr_ui   = 1'b1;

`ifdef CELL_TOGGLE_EN
  localparam logic [1:0] c_st_rmw_rd = 2'd1;
  localparam logic [1:0] c_st_rmw_wr = 2'd2;
  localparam logic [1:0] c_tag_rmw   = 2'd3;

  logic [ADDR_W-1:0] r_rmw_addr;
  logic              r_rmw_data;
`else
  // Toggle requests degrade to plain writes when the RMW path is absent.
  logic w_unused_toggle;
  assign w_unused_toggle = ui_toggle;
`endif

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic [1:0] r_tag;
  logic [1:0] w_tag_nxt;
  logic       r_ptr;
  logic       w_ptr_nxt;
  logic       w_ui_done_nxt;
  logic       w_pick_eng;
  logic       w_pick_ui;

  // Round-robin pick between engine and UI; only meaningful in ARB without VGA.
  assign w_pick_eng = eng_req && (!ui_req || (r_ptr == c_ptr_eng));
  assign w_pick_ui  = ui_req && !w_pick_eng;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_st_arb;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = c_st_arb;
`ifdef CELL_TOGGLE_EN
    case (r_state)
      c_st_arb:    w_state_nxt = (ui_gnt && ui_toggle) ? c_st_rmw_rd : c_st_arb;
      c_st_rmw_rd: w_state_nxt = c_st_rmw_wr;
      // The write waits out any VGA cycle; the port stays locked to the UI.
      c_st_rmw_wr: w_state_nxt = vga_active ? c_st_rmw_wr : c_st_arb;
      default:     w_state_nxt = c_st_arb;
    endcase
`endif
  end

  // Output logic: grants and RAM strobes, all forced low while in reset
  always_comb begin
    eng_gnt       = 1'b0;
    ui_gnt        = 1'b0;
    mem_en        = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = 1'b0;
    w_tag_nxt     = c_tag_none;
    w_ptr_nxt     = r_ptr;
    w_ui_done_nxt = 1'b0;
    if (rst_n) begin
      if (vga_active) begin
        // VGA pre-empts everything; a waiting requester simply keeps waiting.
        mem_en    = 1'b1;
        mem_addr  = vga_addr;
        w_tag_nxt = c_tag_vga;
      end else begin
        case (r_state)
          c_st_arb: begin
            if (w_pick_eng) begin
              eng_gnt   = 1'b1;
              mem_en    = 1'b1;
              mem_we    = eng_we;
              mem_addr  = eng_addr;
              mem_wdata = eng_wdata;
              w_tag_nxt = eng_we ? c_tag_none : c_tag_eng;
              w_ptr_nxt = c_ptr_ui;
            end else if (w_pick_ui) begin
              ui_gnt    = 1'b1;
              mem_en    = 1'b1;
              mem_addr  = ui_addr;
              w_ptr_nxt = c_ptr_eng;
`ifdef CELL_TOGGLE_EN
              if (ui_toggle) begin
                w_tag_nxt = c_tag_rmw;
              end else begin
                mem_we        = 1'b1;
                mem_wdata     = ui_wdata;
                w_ui_done_nxt = 1'b1;
              end
`else
              mem_we        = 1'b1;
              mem_wdata     = ui_wdata;
              w_ui_done_nxt = 1'b1;
`endif
            end
          end
`ifdef CELL_TOGGLE_EN
          c_st_rmw_wr: begin
            mem_en        = 1'b1;
            mem_we        = 1'b1;
            mem_addr      = r_rmw_addr;
            mem_wdata     = ~r_rmw_data;
            w_ui_done_nxt = 1'b1;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  // Pointer, read tag and read-return registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= c_ptr_eng;
      r_tag      <= c_tag_none;
      vga_live   <= 1'b0;
      eng_rdata  <= 1'b0;
      eng_rvalid <= 1'b0;
      ui_done    <= 1'b0;
    end else begin
      r_ptr      <= w_ptr_nxt;
      r_tag      <= w_tag_nxt;
      ui_done    <= w_ui_done_nxt;
      eng_rvalid <= (r_tag == c_tag_eng);
      if (r_tag == c_tag_vga) vga_live  <= mem_rdata;
      if (r_tag == c_tag_eng) eng_rdata <= mem_rdata;
    end
  end

`ifdef CELL_TOGGLE_EN
  // The requester may move on after its grant, so keep our own copy of the
  // target address and the value read back for inversion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rmw_addr <= '0;
      r_rmw_data <= 1'b0;
    end else begin
      if (ui_gnt)               r_rmw_addr <= ui_addr;
      if (r_tag == c_tag_rmw)   r_rmw_data <= mem_rdata;
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/cell_mem_arbiter.md
Name: cell_mem_arbiter

Overview:
- Owns the single-port cell-state RAM (1 bit per cell) and shares it between three requesters: VGA scan-out reads, the life-update engine, and the manual-setting UI.
- VGA has absolute priority while pixels are visible, so the display never misses a cell.
- Engine and UI share every remaining cycle round-robin.
- Sits between the vga block, the generation engine, the setting controller and the cell RAM.

Parameters:
- ADDR_W, 12, cell address width (cell index = row * P_PARAM_N + col).
- P_PARAM_N, 64, cells per row; informational only, no arithmetic inside.

Ports:
- clk  in  1  system/pixel clock.
- rst_n  in  1  reset; asynchronous, active-low.
- vga_active  in  1  VGA owns the port this cycle (driven from the scan's data_enable timing).
- vga_addr  in  ADDR_W  cell the VGA is fetching.
- vga_live  out  1  registered read data for VGA.
- eng_req  in  1  engine access request.
- eng_we  in  1  1 = write, 0 = read.
- eng_addr  in  ADDR_W  engine address.
- eng_wdata  in  1  engine write data.
- eng_gnt  out  1  engine transfer accepted this cycle.
- eng_rdata  out  1  engine read data.
- eng_rvalid  out  1  eng_rdata valid.
- ui_req  in  1  UI write/toggle request.
- ui_toggle  in  1  request is an invert of the cell (optional feature only).
- ui_addr  in  ADDR_W  UI address.
- ui_wdata  in  1  UI write value.
- ui_gnt  out  1  UI request accepted.
- ui_done  out  1  UI operation complete pulse.
- mem_en, mem_we  out  1 each  RAM strobes.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  1  RAM write data.
- mem_rdata  in  1  RAM read data, synchronous, 1-cycle latency.

Behaviour:
- Reset, asynchronous, all state cleared:
  - vga_live=0, eng_rdata=0, eng_rvalid=0, ui_done=0.
  - RR pointer = ENGINE; FSM = ARB; read tag = NONE.
  - eng_gnt, ui_gnt, mem_en, mem_we forced 0 while rst_n=0.
- Grants and mem_* are combinational from current inputs and state.
- A transfer occurs on req & gnt at the rising edge.
- Requesters hold req, we, addr and wdata stable until granted.
- Priority each cycle in ARB:
  1. vga_active=1: mem_en=1, mem_we=0, mem_addr=vga_addr, tag=VGA. eng_gnt=ui_gnt=0.
  2. Otherwise, a single requesting source is granted.
  3. Otherwise, if both request, the source equal to the RR pointer wins.
  4. After any engine/UI grant the pointer moves to the other source. The pointer is unchanged on VGA or idle cycles.
  5. No request: mem_en=0, tag=NONE.
- Read return:
  - The tag is registered. One cycle after a VGA read, vga_live <= mem_rdata.
  - One cycle after an engine read, eng_rdata <= mem_rdata and eng_rvalid=1 for exactly one cycle.
  - vga_live holds its value on non-VGA cycles.
- Writes: mem_we=1, mem_wdata = source wdata.
  - Engine write: no rvalid.
  - UI write: ui_done pulses 1 cycle after the grant cycle.
- Back-to-back: the engine can be granted every non-VGA cycle when alone. Throughput is 1 access/cycle.
- vga_active rising while a requester waits: the requester is stalled. The grant is not lost, and the pointer is not advanced.
- Address wrap: none; addresses pass through unmodified. Out-of-range values are the caller's responsibility.
- Simultaneous eng_rvalid and a new eng_gnt is legal (pipelined reads).

Optional Feature:
- Macro: CELL_TOGGLE_EN.
- Defined:
  - A UI grant with ui_toggle=1 starts a locked read-modify-write: ARB -> RMW_RD (read issued in the grant cycle, tag=RMW) -> RMW_WR.
  - In RMW_WR the arbiter writes !captured_data to the latched ui_addr, then pulses ui_done and returns to ARB.
  - If vga_active=1 in RMW_WR, VGA is served and the write waits; the engine is never granted between the read and the write.
  - Reset in RMW_RD or RMW_WR aborts with no write and no ui_done.
- Not defined: ui_toggle is ignored (treated as a plain write of ui_wdata); FSM has only ARB.

Test Plan:
- Reset then vga_active=1, vga_addr=5, RAM[5]=1, eng_req=1 -> eng_gnt=0 throughout; vga_live=1 one cycle after the read; eng_gnt=1 on the first cycle vga_active=0.
- eng_req and ui_req both held, vga_active=0, pointer=ENGINE -> grants alternate E,U,E,U; ui_done is 1 a cycle after each U grant.
- Engine reads addr 3, 4, 5 back-to-back, RAM = 1, 0, 1 -> eng_rvalid high 3 consecutive cycles with eng_rdata 1, 0, 1.
- UI write addr 10 data 1, then engine read addr 10 -> eng_rdata=1.
- CELL_TOGGLE_EN: RAM[7]=0, ui toggle addr 7 with vga_active pulsed high in RMW_WR -> write delayed one cycle; RAM[7]=1; ui_done once; eng_req meanwhile not granted until done.
- Assert rst_n=0 mid-RMW -> all outputs 0 immediately; RAM[7] unchanged; no ui_done after release.
